// File: rtl/pipe_mem_arbiter_pkg.sv
// Shared constants for the buffer-memory arbiter: default requester indices and
// the index-width helper used to size owner/burst registers.
package pipe_mem_arbiter_pkg;

    localparam int REQ_PIPE_IN  = 0;
    localparam int REQ_RX       = 1;
    localparam int REQ_PIPE_OUT = 2;

    // Width needed to hold an index 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_mem_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request scanning from start,
// wrapping around, returned both one-hot and as an index.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  pick_oh,
    output logic [IW-1:0] pick_idx,
    output logic          pick_any
);

    int j;

    always_comb begin
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(start) + k) % N;
            if (!pick_any && req[j]) begin
                pick_any   = 1'b1;
                pick_oh[j] = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one single-port sync-read RAM.
// Optional `ARB_STATS_EN adds saturating per-requester grant counters.
module pipe_mem_arbiter
    import pipe_mem_arbiter_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH = 5,
    parameter int MEM_DATA_WIDTH = 16,
    parameter int N_REQ          = 3,
    parameter int MAX_BURST      = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [N_REQ-1:0]                  req,
    input  logic [N_REQ-1:0]                  we,
    input  logic [N_REQ*MEM_ADDR_WIDTH-1:0]   addr,
    input  logic [N_REQ*MEM_DATA_WIDTH-1:0]   wdata,
    output logic [N_REQ-1:0]                  gnt,
    output logic [N_REQ-1:0]                  rvalid,
    output logic [MEM_DATA_WIDTH-1:0]         rdata,
    output logic                              mem_en,
    output logic                              mem_we,
    output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
    output logic [MEM_DATA_WIDTH-1:0]         mem_wdata,
    input  logic [MEM_DATA_WIDTH-1:0]         mem_rdata
`ifdef ARB_STATS_EN
    ,
    input  logic                              stats_clr,
    output logic [N_REQ*16-1:0]               grant_cnt
`endif
);

    localparam int IW = idx_width(N_REQ);
    localparam int BW = idx_width(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    logic [IW-1:0]    owner_q, owner_d, start_idx, pick_idx, sel_idx;
    logic [BW-1:0]    burst_cnt_q, burst_cnt_d;
    logic [N_REQ-1:0] rd_pend_q, rd_pend_d, pick_oh;
    logic             hold_q, hold_d;
    logic             pick_any, keep_owner;

    assign start_idx = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

    rr_pick #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr_pick (
        .req      (req),
        .start    (start_idx),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // hold_q is clear out of reset so the reset owner cannot extend a burst it
    // never started; the first grant then goes round-robin from requester 0.
    always_comb begin
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        hold_d      = hold_q;
        sel_idx     = owner_q;
        gnt         = '0;
        keep_owner  = hold_q && req[owner_q] && (burst_cnt_q < BURST_LAST);
        if (keep_owner) begin
            gnt[owner_q] = 1'b1;
            burst_cnt_d  = burst_cnt_q + BW'(1);
        end else if (pick_any) begin
            gnt         = pick_oh;
            sel_idx     = pick_idx;
            owner_d     = pick_idx;
            burst_cnt_d = '0;
        end
        if (!rst_n) begin
            gnt = '0;
        end
        if (|gnt) begin
            hold_d = 1'b1;
        end
        mem_en    = |gnt;
        mem_we    = mem_en & we[sel_idx];
        mem_addr  = addr[int'(sel_idx)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
        mem_wdata = wdata[int'(sel_idx)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
        rd_pend_d = gnt & ~we;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q     <= IW'(N_REQ - 1);
            burst_cnt_q <= '0;
            rd_pend_q   <= '0;
            hold_q      <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            rd_pend_q   <= rd_pend_d;
            hold_q      <= hold_d;
        end
    end

    // Gating with rst_n hides a read that was granted just before reset.
    assign rvalid = rd_pend_q & {N_REQ{rst_n}};
    assign rdata  = mem_rdata;

`ifdef ARB_STATS_EN
    logic [N_REQ*16-1:0] grant_cnt_q, grant_cnt_d;

    always_comb begin
        grant_cnt_d = grant_cnt_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (stats_clr) begin
                grant_cnt_d[i*16 +: 16] = '0;
            end else if (gnt[i] && (grant_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                grant_cnt_d[i*16 +: 16] = grant_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            grant_cnt_q <= '0;
        end else begin
            grant_cnt_q <= grant_cnt_d;
        end
    end

    assign grant_cnt = grant_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Self-checking bench for pipe_mem_arbiter: directed table and corner sequences
// plus randomized traffic checked against a rule-level reference model.
module tb_pipe_mem_arbiter;
    import pipe_mem_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 16;
    localparam int MB = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic            mem_en, mem_we;
    logic [AW-1:0]   mem_addr;
`ifdef ARB_STATS_EN
    logic            stats_clr;
    logic [N*16-1:0] grant_cnt;
`endif

    logic          req_v [N];
    logic          we_v [N];
    logic [AW-1:0] addr_v [N];
    logic [DW-1:0] wdata_v [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req[i]            = req_v[i];
            we[i]             = we_v[i];
            addr[i*AW +: AW]  = addr_v[i];
            wdata[i*DW +: DW] = wdata_v[i];
        end
    end

    always #5 clk = ~clk;

    pipe_mem_arbiter #(
        .MEM_ADDR_WIDTH (AW),
        .MEM_DATA_WIDTH (DW),
        .N_REQ          (N),
        .MAX_BURST      (MB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef ARB_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    // Write-first single-port RAM attached to the arbiter.
    logic [DW-1:0] ram [32];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= mem_we ? mem_wdata : ram[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: the arbitration rules stated directly on integers.
    int            m_own, m_burst, m_pend, exp_win, last_win;
    bit            m_started, m_stay, m_pend_known;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] ref_mem [32];
    bit            ref_written [32];
    logic [N-1:0]  last_gnt, last_rvalid;
    logic [DW-1:0] last_rdata;

    task automatic model_eval();
        exp_win = -1;
        m_stay  = 0;
        if (rst_n) begin
            if (m_started && req_v[m_own] && (m_burst < MB - 1)) begin
                exp_win = m_own;
                m_stay  = 1;
            end else begin
                for (int k = 1; k <= N; k++) begin
                    int j = (m_own + k) % N;
                    if (exp_win < 0 && req_v[j]) exp_win = j;
                end
            end
        end
    endtask

    task automatic model_update();
        last_win = exp_win;
        if (!rst_n) begin
            m_own = N - 1; m_burst = 0; m_pend = -1; m_started = 0;
        end else if (exp_win >= 0) begin
            if (m_stay) m_burst++;
            else begin m_own = exp_win; m_burst = 0; end
            m_started = 1;
            if (we_v[exp_win]) begin
                ref_mem[addr_v[exp_win]]     = wdata_v[exp_win];
                ref_written[addr_v[exp_win]] = 1;
                m_pend = -1;
            end else begin
                m_pend       = exp_win;
                m_pend_data  = ref_mem[addr_v[exp_win]];
                m_pend_known = ref_written[addr_v[exp_win]];
            end
        end else begin
            m_pend = -1;
        end
    endtask

    task automatic tick();
        logic [N-1:0] eg, ev;
        @(negedge clk);
        model_eval();
        eg = '0;
        if (exp_win >= 0) eg[exp_win] = 1'b1;
        ev = '0;
        if (rst_n && m_pend >= 0) ev[m_pend] = 1'b1;
        chk("gnt", gnt, eg);
        chk("mem_en", mem_en, |eg);
        if (exp_win >= 0) begin
            chk("mem_we", mem_we, we_v[exp_win]);
            chk("mem_addr", mem_addr, addr_v[exp_win]);
            if (we_v[exp_win]) chk("mem_wdata", mem_wdata, wdata_v[exp_win]);
        end
        chk("rvalid", rvalid, ev);
        if (ev != 0 && m_pend_known) chk("rdata", rdata, m_pend_data);
        last_gnt    = gnt;
        last_rvalid = rvalid;
        last_rdata  = rdata;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_req(input logic [N-1:0] r, input logic [N-1:0] w);
        for (int i = 0; i < N; i++) begin
            req_v[i] = r[i];
            we_v[i]  = w[i];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_req('0, '0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] exp_gnt;
    } vec_t;
    vec_t tbl [13];

    initial begin
        for (int i = 0; i < 13; i++) begin
            tbl[i].req     = 3'b111;
            tbl[i].exp_gnt = 3'b001 << ((i / MB) % N);
        end
        for (int i = 0; i < 32; i++) ref_written[i] = 0;
        for (int i = 0; i < N; i++) begin
            addr_v[i]  = AW'(i);
            wdata_v[i] = '0;
        end
        m_own = N - 1; m_burst = 0; m_pend = -1; m_started = 0; last_win = -1;
`ifdef ARB_STATS_EN
        stats_clr = 1'b0;
`endif
        do_reset();

        // Idle after reset, then reset asserted with everyone requesting.
        tick();
        chk("reset_gnt", last_gnt, 3'b000);
        chk("reset_rvalid", last_rvalid, 3'b000);
        rst_n = 1'b0;
        set_req(3'b111, 3'b111);
        tick();
        chk("gnt_in_reset", last_gnt, 3'b000);
        rst_n = 1'b1;
        set_req('0, '0);
        tick();

        // All three writing continuously: bursts of MAX_BURST in turn.
        do_reset();
        for (int i = 0; i < 13; i++) begin
            set_req(tbl[i].req, 3'b111);
            for (int r = 0; r < N; r++) begin
                addr_v[r]  = AW'(20 + r);
                wdata_v[r] = DW'($urandom);
            end
            tick();
            chk($sformatf("rr_tbl[%0d]", i), last_gnt, tbl[i].exp_gnt);
        end

        // Pre-write 0..9 via pipe-in, then stream reads from pipe-out.
        for (int a = 0; a < 10; a++) begin
            set_req(3'b001, 3'b001);
            addr_v[REQ_PIPE_IN]  = AW'(a);
            wdata_v[REQ_PIPE_IN] = DW'(a + 1);
            tick();
            chk("prewrite_gnt", last_gnt, 3'b001);
        end
        for (int a = 0; a <= 10; a++) begin
            if (a < 10) begin
                set_req(3'b100, 3'b000);
                addr_v[REQ_PIPE_OUT] = AW'(a);
            end else begin
                set_req(3'b000, 3'b000);
            end
            tick();
            if (a < 10) chk("stream_gnt", last_gnt, 3'b100);
            if (a > 0) begin
                chk("stream_rvalid", last_rvalid, 3'b100);
                chk("stream_rdata", last_rdata, DW'(a));
            end
        end

        // Write then read of the same address in consecutive cycles.
        set_req(3'b001, 3'b001);
        addr_v[REQ_PIPE_IN]  = 5'd5;
        wdata_v[REQ_PIPE_IN] = 16'hBEEF;
        tick();
        set_req(3'b100, 3'b000);
        addr_v[REQ_PIPE_OUT] = 5'd5;
        tick();
        set_req(3'b000, 3'b000);
        tick();
        chk("wr_rd_rvalid", last_rvalid, 3'b100);
        chk("wr_rd_rdata", last_rdata, 16'hBEEF);

        // Owner 1 drops its request mid-burst; scan resumes at owner+1.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_req(3'b010, 3'b111);
            tick();
            chk("mid_burst_gnt", last_gnt, 3'b010);
        end
        for (int i = 0; i < 5; i++) begin
            set_req(3'b101, 3'b111);
            tick();
            chk($sformatf("after_drop_gnt[%0d]", i), last_gnt, (i < MB) ? 3'b100 : 3'b001);
        end

        // Read granted, then reset the following cycle: no rvalid.
        do_reset();
        set_req(3'b100, 3'b000);
        addr_v[REQ_PIPE_OUT] = 5'd5;
        tick();
        chk("rd_before_rst_gnt", last_gnt, 3'b100);
        rst_n = 1'b0;
        set_req(3'b000, 3'b000);
        tick();
        chk("rd_before_rst_rvalid", last_rvalid, 3'b000);
        rst_n = 1'b1;
        tick();
        chk("rd_after_rst_rvalid", last_rvalid, 3'b000);
        set_req(3'b111, 3'b111);
        tick();
        chk("first_after_rst", last_gnt, 3'b001);

        // Randomized traffic honouring the hold-until-grant rule.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_v[i] || last_win == i) begin
                    req_v[i]   = ($urandom_range(0, 3) != 0);
                    we_v[i]    = 1'($urandom_range(0, 1));
                    addr_v[i]  = AW'($urandom_range(0, 31));
                    wdata_v[i] = DW'($urandom);
                end
            end
            tick();
        end

`ifdef ARB_STATS_EN
        do_reset();
        chk("stats_reset", grant_cnt, '0);
        set_req(3'b010, 3'b010);
        for (int c = 0; c < 70000; c++) tick();
        chk("stats_sat", grant_cnt[REQ_RX*16 +: 16], 16'hFFFF);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("stats_clr", grant_cnt, '0);
        set_req(3'b000, 3'b000);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
